// File: rtl/router_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | router_pkg : constants shared by the router FSM, FIFOs and regs    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package router_pkg;

  localparam int         DATA_W_DEF     = 8;
  localparam logic [1:0] ADDR_INVALID   = 2'b11;
  localparam logic       PARITY_RST_BIT = 1'b0;

  function automatic logic addr_valid(input logic [1:0] addr);
    return addr != ADDR_INVALID;
  endfunction

endpackage
`default_nettype wire

// File: rtl/router_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | router_if : controller/source side signals of the router register  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface router_if
  import router_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) ();

  logic              pkt_valid;
  logic [DATA_W-1:0] data_in;
  logic              fifo_full;
  logic              detect_add;
  logic              lfd_state;
  logic              ld_state;
  logic              laf_state;
  logic              full_state;
  logic              rst_int_reg;
  logic [DATA_W-1:0] dout;
  logic              parity_done;
  logic              low_packet_valid;
  logic              err;

  modport master (
    output pkt_valid, data_in, fifo_full, detect_add, lfd_state, ld_state,
           laf_state, full_state, rst_int_reg,
    input  dout, parity_done, low_packet_valid, err
  );

  modport slave (
    input  pkt_valid, data_in, fifo_full, detect_add, lfd_state, ld_state,
           laf_state, full_state, rst_int_reg,
    output dout, parity_done, low_packet_valid, err
  );

endinterface
`default_nettype wire

// File: rtl/router_parity.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | router_parity : running and received packet parity, error flag     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module router_parity
  import router_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              detect_add,
  input  wire logic              lfd_state,
  input  wire logic              ld_state,
  input  wire logic              pkt_valid,
  input  wire logic [DATA_W-1:0] data_in,
  input  wire logic [DATA_W-1:0] header,
  input  wire logic [DATA_W-1:0] hold,
  input  wire logic              cap_data,
  input  wire logic              cap_hold,
  input  wire logic              parity_done,
  output      logic              err
);

  localparam logic [DATA_W-1:0] C_PAR_RST = {DATA_W{PARITY_RST_BIT}};

  logic [DATA_W-1:0] r_int_par;
  logic [DATA_W-1:0] r_pkt_par;
  logic              r_err;

  // Bytes stalled by a full FIFO are folded in on arrival, never on replay.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_int_par <= C_PAR_RST;
      r_pkt_par <= C_PAR_RST;
      r_err     <= 1'b0;
    end else begin
      if (detect_add)
        r_int_par <= C_PAR_RST;
      else if (lfd_state)
        r_int_par <= r_int_par ^ header;
      else if (ld_state && pkt_valid)
        r_int_par <= r_int_par ^ data_in;

      if (detect_add)
        r_pkt_par <= C_PAR_RST;
      else if (cap_data)
        r_pkt_par <= data_in;
      else if (cap_hold)
        r_pkt_par <= hold;

      if (detect_add)
        r_err <= 1'b0;
      else if (parity_done)
        r_err <= (r_int_par != r_pkt_par);
    end
  end

  assign err = r_err;

endmodule
`default_nettype wire

// File: rtl/router_reg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | router_reg : header/hold/output byte registers of the packet router |
// | Parity check built only with ROUTER_PARITY_CHK_EN.  Rev 1.0         |
// +--------------------------------------------------------------------+
module router_reg
  import router_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input wire logic clk,
  input wire logic rst,
  router_if.slave  bus
);

  logic [DATA_W-1:0] r_header;
  logic [DATA_W-1:0] r_hold;
  logic [DATA_W-1:0] r_dout;
  logic              r_parity_done;
  logic              r_low_pkt_valid;
  logic              w_cap_data;
  logic              w_cap_hold;
  logic              w_err;
  logic              w_unused_ok;

  assign w_cap_data  = bus.ld_state && !bus.pkt_valid;
  assign w_cap_hold  = bus.laf_state && r_low_pkt_valid && !r_parity_done;
  assign w_unused_ok = bus.full_state;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_header        <= '0;
      r_hold          <= '0;
      r_dout          <= '0;
      r_parity_done   <= 1'b0;
      r_low_pkt_valid <= 1'b0;
    end else begin
      if (bus.detect_add && bus.pkt_valid && addr_valid(bus.data_in[1:0]))
        r_header <= bus.data_in;

      if (bus.ld_state && bus.fifo_full)
        r_hold <= bus.data_in;

      // A byte refused by a full FIFO reappears from r_hold in load-after-full.
      if (bus.lfd_state)
        r_dout <= r_header;
      else if (bus.ld_state && !bus.fifo_full)
        r_dout <= bus.data_in;
      else if (bus.laf_state)
        r_dout <= r_hold;

      if (bus.detect_add)
        r_parity_done <= 1'b0;
      else if (w_cap_data || w_cap_hold)
        r_parity_done <= 1'b1;

      if (bus.rst_int_reg)
        r_low_pkt_valid <= 1'b0;
      else if (w_cap_data)
        r_low_pkt_valid <= 1'b1;
    end
  end

`ifdef ROUTER_PARITY_CHK_EN
  router_parity #(
    .DATA_W (DATA_W)
  ) u_parity (
    .clk         (clk),
    .rst         (rst),
    .detect_add  (bus.detect_add),
    .lfd_state   (bus.lfd_state),
    .ld_state    (bus.ld_state),
    .pkt_valid   (bus.pkt_valid),
    .data_in     (bus.data_in),
    .header      (r_header),
    .hold        (r_hold),
    .cap_data    (w_cap_data),
    .cap_hold    (w_cap_hold),
    .parity_done (r_parity_done),
    .err         (w_err)
  );
`else
  assign w_err = 1'b0;
`endif

  assign bus.dout             = r_dout;
  assign bus.parity_done      = r_parity_done;
  assign bus.low_packet_valid = r_low_pkt_valid;
  assign bus.err              = w_err;

endmodule
`default_nettype wire
